leb128_unpack: RTL

- Byte-serial decoder for unsigned LEB128 (ULEB128). It is the receive-side counterpart of the combinational u32 packer.
- Consumes one encoded byte per accepted input handshake. LSB group comes first, and bit 7 is the continuation flag.
- Accumulates 7-bit groups into a W-bit value. Emits one result word per encoding, with byte length and an error flag.
- Sits between a byte-stream source (FIFO or deserializer) and a word consumer. Valid/ready on both sides.

---
 rtl/leb128_unpack.sv | 128 ++++++++++++
 1 files changed

// File: rtl/leb128_unpack.sv
// Byte-serial unsigned LEB128 decoder with valid/ready on both sides.
// Define LEB128_UNPACK_CANON_EN to flag over-padded (non-canonical) encodings as errors.
module leb128_unpack #(
    parameter  int W    = 32,
    localparam int MAXB = (W + 6) / 7,
    localparam int LW   = $clog2(MAXB + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    i_data,
    input  logic          i_valid,
    output logic          i_ready,
    output logic [W-1:0]  o_data,
    output logic [LW-1:0] o_len,
    output logic          o_err,
    output logic          o_valid,
    input  logic          o_ready
);

    typedef enum logic {ACC, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] k_q, k_d;
    logic [W-1:0]  acc_q, acc_d;
    logic          ovf_q, ovf_d;
    logic          o_valid_q, o_valid_d;
    logic [W-1:0]  o_data_q, o_data_d;
    logic [LW-1:0] o_len_q, o_len_d;
    logic          o_err_q, o_err_d;

    logic          in_fire;
    logic [W+6:0]  grp_shift;
    logic [W-1:0]  acc_new;
    logic          ovf_new;
    logic          term_err;

    assign i_ready = !o_valid_q || o_ready;
    assign in_fire = i_valid && i_ready;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_len_d   = o_len_q;
        o_err_d   = o_err_q;

        // Payload bits landing at or above bit W can only come from the last legal byte.
        grp_shift = {{W{1'b0}}, i_data[6:0]} << (7 * k_q);
        acc_new   = acc_q | grp_shift[W-1:0];
        ovf_new   = ovf_q || (|grp_shift[W+6:W]);
`ifdef LEB128_UNPACK_CANON_EN
        term_err  = ovf_new || ((k_q != '0) && (i_data[6:0] == 7'd0));
`else
        term_err  = ovf_new;
`endif

        if (o_valid_q && o_ready) begin
            o_valid_d = 1'b0;
        end

        if (in_fire) begin
            case (state_q)
                ACC: begin
                    if (!i_data[7]) begin
                        o_valid_d = 1'b1;
                        o_data_d  = acc_new;
                        o_len_d   = k_q + 1'b1;
                        o_err_d   = term_err;
                        k_d       = '0;
                        acc_d     = '0;
                        ovf_d     = 1'b0;
                    end else if (k_q == LW'(MAXB - 1)) begin
                        o_valid_d = 1'b1;
                        o_data_d  = acc_new;
                        o_len_d   = LW'(MAXB);
                        o_err_d   = 1'b1;
                        k_d       = '0;
                        acc_d     = '0;
                        ovf_d     = 1'b0;
                        state_d   = DRAIN;
                    end else begin
                        k_d       = k_q + 1'b1;
                        acc_d     = acc_new;
                        ovf_d     = ovf_new;
                    end
                end
                DRAIN: begin
                    if (!i_data[7]) begin
                        state_d = ACC;
                    end
                end
                default: state_d = ACC;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACC;
            k_q       <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_len_q   <= '0;
            o_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_len_q   <= o_len_d;
            o_err_q   <= o_err_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_len   = o_len_q;
    assign o_err   = o_err_q;

endmodule
